// File: rtl/sha256_padder.sv
// SHA-256 message padder: turns an arbitrary-length big-endian word stream into complete 512-bit blocks.
// Optional build macro SHA_PAD_BYTESWAP_EN byte-reverses iData on entry for little-endian buffers.
module sha256_padder #(
  parameter int LEN_W = 32
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iData,
  input  logic        iValid,
  input  logic        iLast,
  input  logic [1:0]  iBytes,
  output logic        oReady,
  output logic [31:0] oData,
  output logic        oValid,
  input  logic        iReady,
  output logic        oBlockEnd,
  output logic        oMsgEnd,
  output logic [31:0] oBlockCount,
  output logic        oBusy
);

  typedef enum logic [1:0] {
    S_PASS  = 2'd0,
    S_PAD80 = 2'd1,
    S_ZERO  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [3:0]        w, w_n;
  logic [LEN_W-1:0]  byte_cnt, byte_cnt_n;
  logic              extra, extra_n;
  logic [31:0]       data_n;
  logic              valid_n, blk_end_n, msg_end_n, busy_n;
  logic [31:0]       blk_cnt_n;

  logic              load, accept;
  logic [31:0]       word_in, pad_word;
  logic [LEN_W-1:0]  byte_inc;
  logic [63:0]       len_bits;

`ifdef SHA_PAD_BYTESWAP_EN
  assign word_in = {iData[7:0], iData[15:8], iData[23:16], iData[31:24]};
`else
  assign word_in = iData;
`endif

  assign load     = !oValid || iReady;
  assign oReady   = (state == S_PASS) && load;
  assign accept   = iValid && oReady;
  assign len_bits = 64'(byte_cnt) << 3;
  assign byte_inc = (iLast && (iBytes != 2'd0)) ? LEN_W'(iBytes) : LEN_W'(3'd4);

  // Keep the valid leading bytes of a short final word and drop the 0x80 marker right after them.
  always_comb begin
    pad_word = word_in;
    if (iLast) begin
      case (iBytes)
        2'd1:    pad_word = {word_in[31:24], 8'h80, 16'h0000};
        2'd2:    pad_word = {word_in[31:16], 8'h80, 8'h00};
        2'd3:    pad_word = {word_in[31:8], 8'h80};
        default: pad_word = word_in;
      endcase
    end
  end

  // Next-state and next-output logic; everything holds unless the output register may load.
  always_comb begin
    state_n    = state;
    w_n        = w;
    byte_cnt_n = byte_cnt;
    extra_n    = extra;
    data_n     = oData;
    valid_n    = oValid;
    blk_end_n  = oBlockEnd;
    msg_end_n  = oMsgEnd;
    busy_n     = oBusy;
    blk_cnt_n  = oBlockCount;

    if (oValid && iReady && oBlockEnd)
      blk_cnt_n = oBlockCount + 32'd1;
    if (accept) begin
      busy_n = 1'b1;
      if (!oBusy)
        blk_cnt_n = 32'd0;
    end

    case (state)
      S_PASS: begin
        if (load) begin
          valid_n   = accept;
          blk_end_n = 1'b0;
          msg_end_n = 1'b0;
          if (accept) begin
            data_n     = pad_word;
            blk_end_n  = (w == 4'd15);
            w_n        = w + 4'd1;
            byte_cnt_n = byte_cnt + byte_inc;
            if (iLast) begin
              if (iBytes == 2'd0) begin
                state_n = S_PAD80;
              end else begin
                state_n = S_ZERO;
                extra_n = (w >= 4'd14);
              end
            end
          end
        end
      end

      S_PAD80: begin
        if (load) begin
          valid_n   = 1'b1;
          data_n    = 32'h8000_0000;
          blk_end_n = (w == 4'd15);
          msg_end_n = 1'b0;
          w_n       = w + 4'd1;
          extra_n   = (w >= 4'd14);
          state_n   = S_ZERO;
        end
      end

      S_ZERO: begin
        if (load) begin
          // A held length word can only be leaving here, so this load closes the message.
          if (oValid && oMsgEnd) begin
            valid_n    = 1'b0;
            data_n     = 32'h0;
            blk_end_n  = 1'b0;
            msg_end_n  = 1'b0;
            busy_n     = 1'b0;
            w_n        = 4'd0;
            byte_cnt_n = '0;
            state_n    = S_PASS;
          end else begin
            valid_n   = 1'b1;
            blk_end_n = (w == 4'd15);
            w_n       = w + 4'd1;
            if (extra) begin
              data_n    = 32'h0;
              msg_end_n = 1'b0;
              if (w == 4'd15)
                extra_n = 1'b0;
            end else begin
              msg_end_n = (w == 4'd15);
              if (w == 4'd14)
                data_n = len_bits[63:32];
              else if (w == 4'd15)
                data_n = len_bits[31:0];
              else
                data_n = 32'h0;
            end
          end
        end
      end

      default: state_n = S_PASS;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state       <= S_PASS;
      w           <= 4'd0;
      byte_cnt    <= '0;
      extra       <= 1'b0;
      oData       <= 32'h0;
      oValid      <= 1'b0;
      oBlockEnd   <= 1'b0;
      oMsgEnd     <= 1'b0;
      oBusy       <= 1'b0;
      oBlockCount <= 32'd0;
    end else begin
      state       <= state_n;
      w           <= w_n;
      byte_cnt    <= byte_cnt_n;
      extra       <= extra_n;
      oData       <= data_n;
      oValid      <= valid_n;
      oBlockEnd   <= blk_end_n;
      oMsgEnd     <= msg_end_n;
      oBusy       <= busy_n;
      oBlockCount <= blk_cnt_n;
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: known padding vectors, backpressure, reset abort, back-to-back messages.
// With SHA_PAD_BYTESWAP_EN defined the bench feeds byte-reversed words so the same expectations hold.
module tb_sha256_padder;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [31:0] iData;
  logic        iValid;
  logic        iLast;
  logic [1:0]  iBytes;
  logic        oReady;
  logic [31:0] oData;
  logic        oValid;
  logic        iReady;
  logic        oBlockEnd;
  logic        oMsgEnd;
  logic [31:0] oBlockCount;
  logic        oBusy;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;
  int me_count     = 0;
  int me_cycle     = 0;

  logic [31:0] got_data[$];
  bit          got_be[$];
  bit          got_me[$];

  sha256_padder #(.LEN_W(32)) dut (
    .iClk(iClk), .iRst(iRst), .iData(iData), .iValid(iValid), .iLast(iLast),
    .iBytes(iBytes), .oReady(oReady), .oData(oData), .oValid(oValid),
    .iReady(iReady), .oBlockEnd(oBlockEnd), .oMsgEnd(oMsgEnd),
    .oBlockCount(oBlockCount), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) cycle <= cycle + 1;

  // Record every output word that will transfer on the coming rising edge.
  always @(negedge iClk) begin
    if (!iRst && oValid && iReady) begin
      got_data.push_back(oData);
      got_be.push_back(oBlockEnd);
      got_me.push_back(oMsgEnd);
      if (oMsgEnd) begin
        me_count = me_count + 1;
        me_cycle = cycle + 1;
      end
    end
  end

  function automatic logic [31:0] to_dut(input logic [31:0] d);
`ifdef SHA_PAD_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  function automatic logic [31:0] msg_word(input int i);
    logic [7:0] b;
    b = 8'(4 * i);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] nb,
                           output int acc_cycle);
    bit acc;
    acc    = 1'b0;
    iData  = d;
    iLast  = last;
    iBytes = nb;
    iValid = 1'b1;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge iClk);
      acc = oReady;
      @(posedge iClk);
      #1;
    end
    iValid    = 1'b0;
    iLast     = 1'b0;
    iBytes    = 2'd0;
    acc_cycle = cycle;
    tests_run++;
    if (!acc) begin
      tests_failed++;
      $display("[TB] FAIL send_timeout: word %h not accepted, required acceptance within 300 cycles", d);
    end
  endtask

  task automatic send_msg(input int nwords, input logic [1:0] last_bytes);
    int c;
    for (int i = 0; i < nwords; i++)
      send_word(to_dut(msg_word(i)), (i == nwords - 1), last_bytes, c);
  endtask

  task automatic wait_msg_end(input int target);
    for (int i = 0; i < 400 && me_count < target; i++) begin
      @(posedge iClk);
      #1;
    end
    tests_run++;
    if (me_count < target) begin
      tests_failed++;
      $display("[TB] FAIL msg_end_timeout: saw %0d message ends, required %0d", me_count, target);
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1; iValid = 1'b0; iLast = 1'b0; iBytes = 2'd0; iData = 32'h0; iReady = 1'b1;
    @(negedge iClk);
    tests_run++;
    if (oValid !== 1'b0 || oData !== 32'h0 || oBlockEnd !== 1'b0 || oMsgEnd !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: valid=%b data=%h be=%b me=%b, required 0 0 0 0",
               oValid, oData, oBlockEnd, oMsgEnd);
    end
    tests_run++;
    if (oBlockCount !== 32'd0 || oBusy !== 1'b0 || oReady !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: count=%0d busy=%b ready=%b, required 0 0 1",
               oBlockCount, oBusy, oReady);
    end
    @(posedge iClk);
    #1;
    iRst = 1'b0;
  endtask

  task automatic test_abc();
    logic [31:0] exp[16];
    int base, me_base, c, n;
    base    = got_data.size();
    me_base = me_count;
    for (int i = 0; i < 16; i++) exp[i] = 32'h0;
    exp[0]  = 32'h6162_6380;
    exp[15] = 32'h0000_0018;
    send_word(to_dut(32'h6162_6300), 1'b1, 2'd3, c);
    tests_run++;
    if (oValid !== 1'b1 || oData !== 32'h6162_6380) begin
      tests_failed++;
      $display("[TB] FAIL abc_latency: valid=%b data=%h one cycle after accept, required 1 61626380",
               oValid, oData);
    end
    wait_msg_end(me_base + 1);
    n = got_data.size() - base;
    tests_run++;
    if (n !== 16) begin
      tests_failed++;
      $display("[TB] FAIL abc_count: got %0d words, required 16", n);
    end
    for (int i = 0; i < 16 && i < n; i++) begin
      tests_run++;
      if (got_data[base+i] !== exp[i] || got_be[base+i] !== (i == 15) || got_me[base+i] !== (i == 15)) begin
        tests_failed++;
        $display("[TB] FAIL abc_word%0d: got %h be=%b me=%b, required %h be=%b me=%b", i,
                 got_data[base+i], got_be[base+i], got_me[base+i], exp[i], (i == 15), (i == 15));
      end
    end
    tests_run++;
    if (oBlockCount !== 32'd1 || oBusy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abc_status: count=%0d busy=%b, required 1 0", oBlockCount, oBusy);
    end
  endtask

  task automatic test_55_bytes();
    logic [31:0] exp[16];
    int base, me_base, n;
    base    = got_data.size();
    me_base = me_count;
    for (int i = 0; i < 13; i++) exp[i] = msg_word(i);
    exp[13] = 32'h3435_3680;
    exp[14] = 32'h0;
    exp[15] = 32'h0000_01B8;
    send_msg(14, 2'd3);
    wait_msg_end(me_base + 1);
    n = got_data.size() - base;
    tests_run++;
    if (n !== 16) begin
      tests_failed++;
      $display("[TB] FAIL b55_count: got %0d words, required 16", n);
    end
    for (int i = 0; i < 16 && i < n; i++) begin
      tests_run++;
      if (got_data[base+i] !== exp[i] || got_be[base+i] !== (i == 15) || got_me[base+i] !== (i == 15)) begin
        tests_failed++;
        $display("[TB] FAIL b55_word%0d: got %h be=%b me=%b, required %h be=%b me=%b", i,
                 got_data[base+i], got_be[base+i], got_me[base+i], exp[i], (i == 15), (i == 15));
      end
    end
    tests_run++;
    if (oBlockCount !== 32'd1) begin
      tests_failed++;
      $display("[TB] FAIL b55_blocks: count=%0d, required 1", oBlockCount);
    end
  endtask

  task automatic test_56_bytes();
    logic [31:0] exp[32];
    int base, me_base, n;
    base    = got_data.size();
    me_base = me_count;
    for (int i = 0; i < 32; i++) exp[i] = 32'h0;
    for (int i = 0; i < 14; i++) exp[i] = msg_word(i);
    exp[14] = 32'h8000_0000;
    exp[31] = 32'h0000_01C0;
    send_msg(14, 2'd0);
    wait_msg_end(me_base + 1);
    n = got_data.size() - base;
    tests_run++;
    if (n !== 32) begin
      tests_failed++;
      $display("[TB] FAIL b56_count: got %0d words, required 32", n);
    end
    for (int i = 0; i < 32 && i < n; i++) begin
      tests_run++;
      if (got_data[base+i] !== exp[i] || got_be[base+i] !== (i % 16 == 15) || got_me[base+i] !== (i == 31)) begin
        tests_failed++;
        $display("[TB] FAIL b56_word%0d: got %h be=%b me=%b, required %h be=%b me=%b", i,
                 got_data[base+i], got_be[base+i], got_me[base+i], exp[i], (i % 16 == 15), (i == 31));
      end
    end
    tests_run++;
    if (oBlockCount !== 32'd2) begin
      tests_failed++;
      $display("[TB] FAIL b56_blocks: count=%0d, required 2", oBlockCount);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp[48];
    int base, me_base, n, acc_cycle;
    base    = got_data.size();
    me_base = me_count;
    for (int i = 0; i < 48; i++) exp[i] = 32'h0;
    for (int i = 0; i < 16; i++) exp[i] = msg_word(i);
    exp[16] = 32'h8000_0000;
    exp[31] = 32'h0000_0200;
    exp[32] = 32'hDEAD_BEEF;
    exp[33] = 32'h8000_0000;
    exp[47] = 32'h0000_0020;
    send_msg(16, 2'd0);
    send_word(to_dut(32'hDEAD_BEEF), 1'b1, 2'd0, acc_cycle);
    tests_run++;
    if ((me_count - me_base) !== 1 || acc_cycle <= me_cycle) begin
      tests_failed++;
      $display("[TB] FAIL b2b_stall: accept cycle %0d with %0d ends before, required after end cycle %0d with 1 end",
               acc_cycle, me_count - me_base, me_cycle);
    end
    wait_msg_end(me_base + 2);
    n = got_data.size() - base;
    tests_run++;
    if (n !== 48) begin
      tests_failed++;
      $display("[TB] FAIL b2b_count: got %0d words, required 48", n);
    end
    for (int i = 0; i < 48 && i < n; i++) begin
      tests_run++;
      if (got_data[base+i] !== exp[i] || got_be[base+i] !== (i % 16 == 15) ||
          got_me[base+i] !== (i == 31 || i == 47)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_word%0d: got %h be=%b me=%b, required %h be=%b me=%b", i,
                 got_data[base+i], got_be[base+i], got_me[base+i], exp[i], (i % 16 == 15),
                 (i == 31 || i == 47));
      end
    end
    tests_run++;
    if (oBlockCount !== 32'd1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_blocks: count=%0d, required 1", oBlockCount);
    end
  endtask

  task automatic test_backpressure();
    int base, me_base, n, c;
    bit bp5, bp15;
    logic [31:0] held;
    logic        held_me;
    base    = got_data.size();
    me_base = me_count;
    bp5     = 1'b0;
    bp15    = 1'b0;
    send_word(to_dut(32'h6162_6300), 1'b1, 2'd3, c);
    for (int k = 0; k < 200 && me_count < me_base + 1; k++) begin
      if (oValid && ((!bp5 && got_data.size() - base == 5) || (!bp15 && got_data.size() - base == 15))) begin
        if (got_data.size() - base == 5) bp5 = 1'b1;
        else bp15 = 1'b1;
        held    = oData;
        held_me = oMsgEnd;
        iReady  = 1'b0;
        repeat (3) begin
          @(posedge iClk);
          #1;
          tests_run++;
          if (oValid !== 1'b1 || oData !== held || oMsgEnd !== held_me) begin
            tests_failed++;
            $display("[TB] FAIL bp_hold: valid=%b data=%h me=%b, required 1 %h %b",
                     oValid, oData, oMsgEnd, held, held_me);
          end
        end
        iReady = 1'b1;
      end
      @(posedge iClk);
      #1;
    end
    n = got_data.size() - base;
    tests_run++;
    if (n !== 16 || !bp5 || !bp15) begin
      tests_failed++;
      $display("[TB] FAIL bp_count: got %0d words stalls5=%b stalls15=%b, required 16 1 1", n, bp5, bp15);
    end
    for (int i = 0; i < 16 && i < n; i++) begin
      tests_run++;
      if (got_data[base+i] !== ((i == 0) ? 32'h6162_6380 : (i == 15) ? 32'h18 : 32'h0)) begin
        tests_failed++;
        $display("[TB] FAIL bp_word%0d: got %h, required %h", i, got_data[base+i],
                 ((i == 0) ? 32'h6162_6380 : (i == 15) ? 32'h18 : 32'h0));
      end
    end
  endtask

  task automatic test_reset_mid_message();
    int c, base;
    for (int i = 0; i < 7; i++) send_word(to_dut(msg_word(i)), 1'b0, 2'd0, c);
    iRst = 1'b1;
    @(negedge iClk);
    tests_run++;
    if (oValid !== 1'b0 || oData !== 32'h0 || oBlockEnd !== 1'b0 || oMsgEnd !== 1'b0 ||
        oBlockCount !== 32'd0 || oBusy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: valid=%b data=%h be=%b me=%b count=%0d busy=%b, required all 0",
               oValid, oData, oBlockEnd, oMsgEnd, oBlockCount, oBusy);
    end
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    base = got_data.size();
    repeat (6) begin
      @(posedge iClk);
      #1;
    end
    tests_run++;
    if (got_data.size() !== base || oValid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_quiet: %0d words emitted valid=%b, required 0 words valid=0",
               got_data.size() - base, oValid);
    end
    test_abc();
  endtask

`ifdef SHA_PAD_BYTESWAP_EN
  task automatic test_byteswap();
    int c;
    send_word(32'h0063_6261, 1'b1, 2'd3, c);
    tests_run++;
    if (oValid !== 1'b1 || oData !== 32'h6162_6380) begin
      tests_failed++;
      $display("[TB] FAIL byteswap_word0: valid=%b data=%h, required 1 61626380", oValid, oData);
    end
    wait_msg_end(me_count + 1);
  endtask
`endif

  initial begin
    test_reset();
    test_abc();
    test_55_bytes();
    test_56_bytes();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_message();
`ifdef SHA_PAD_BYTESWAP_EN
    test_byteswap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
# sha256_padder

Upstream message-formatting stage for the SHA-256 path. Accepts a 32-bit word stream of arbitrary byte length, appends the SHA-256 padding and the 64-bit message bit-length, and emits a 32-bit stream of complete 512-bit blocks, 16 words per block. Its output feeds the FIFO/DMA path of the SHA-256 controller, so software no longer pre-pads buffers to a multiple of 64 bytes. `oBlockCount` gives the block count that the controller's length register needs.

## Interface
- `LEN_W`, default 32: width of the message byte counter. The bit length is `{byte_cnt, 3'b000}`, zero-extended to 64 bits.
- `iClk` in 1: the single clock. All logic is rising-edge.
- `iRst` in 1: asynchronous, active-high reset.
- `iData` in 32: message word. Byte 0 is in [31:24] (big-endian).
- `iValid` in 1: `iData` is valid.
- `iLast` in 1: this is the final word of the message. Qualified by `iValid`.
- `iBytes` in 2: valid bytes in the last word. 1..3 as is; 0 means 4. Ignored unless `iLast`.
- `oReady` out 1: the block accepts the input word this cycle.
- `oData` out 32: output word.
- `oValid` out 1: `oData` is valid.
- `iReady` in 1: downstream accepts `oData`.
- `oBlockEnd` out 1: `oData` is word 15 of a block.
- `oMsgEnd` out 1: `oData` is the final word of the message (the length low word).
- `oBlockCount` out 32: blocks emitted for the current message. Cleared on the first accepted word of the next message.
- `oBusy` out 1: a message is in progress, meaning a word has been accepted and `oMsgEnd` has not yet transferred.

## Operation
- **Handshakes.** Transfers occur on `iValid & oReady` and on `oValid & iReady`.
- **Output register.** A single registered output stage.
  - `oReady = (state==S_PASS) & (!oValid | iReady)`.
  - The output register loads whenever `!oValid | iReady`.
- **Counters.**
  - `w` (4 bits): index of the next output word within the current block. It wraps from 15 to 0.
  - `byte_cnt` (`LEN_W` bits): adds 4 per accepted non-last word and `iBytes ? iBytes : 4` on the last word. It wraps modulo 2^LEN_W.
- **S_PASS.** Forwards each accepted word.
  - On the last word with `iBytes` = 1..3: bytes at or beyond `iBytes` are replaced with `0x80` followed by zeros. The marker sits in this word, at index m. Next state is S_ZERO.
  - On the last word with `iBytes`=0: the word is forwarded unchanged. Next state is S_PAD80.
- **S_PAD80.** Emits `0x80000000`; this word's index is m. Next state is S_ZERO.
- **Extra-block flag.** On entry to S_ZERO, `extra` = (m ≥ 14). When set, the length does not fit in the current block.
- **S_ZERO.** Emits one word per output load.
  - If `extra`: emits zeros until w==15, then clears `extra`.
  - Else: emits zero for w<14, `len[63:32]` at w==14, and `len[31:0]` at w==15.
  - The w==15 length word asserts `oMsgEnd`. After it transfers, state returns to S_PASS with w=0 and `byte_cnt`=0.
- **Block counting.** `oBlockEnd = (w_of_oData == 15)`. `oBlockCount` increments when a word with `oBlockEnd` transfers.
- **Unsupported input.** Zero-length messages are not supported, because `iLast` always carries at least 1 byte.

## Timing
- **Reset values.** `oValid`=0, `oData`=0, `oBlockEnd`=0, `oMsgEnd`=0, `oBlockCount`=0, `oBusy`=0. State is S_PASS, w=0, `byte_cnt`=0, `extra`=0. `oReady` then evaluates to 1.
- **Latency.** An input word accepted at cycle N is on `oData` at N+1.
- **Padding throughput.** With `iReady` held high, padding words follow the last data word back-to-back at one per cycle.
- **Input stall.** `oReady` is 0 throughout S_PAD80 and S_ZERO. The next message is stalled until `oMsgEnd` transfers.
- **Backpressure.** While `oValid & !iReady`: `oData`, `oBlockEnd` and `oMsgEnd` hold stable, and w, state and the counters do not advance.
- **Reset mid-message.** `iRst` asserted mid-message aborts immediately to the reset values. A partial block is discarded and nothing further is emitted.

## Configuration
- **`SHA_PAD_BYTESWAP_EN` defined:** `iData` is byte-reversed (`{[7:0],[15:8],[23:16],[31:24]}`) before the masking and marker insertion, so little-endian HPS buffers are accepted directly.
  - `iBytes` still counts bytes from message byte 0.
- **Macro not defined:** `iData` is used as-is (big-endian).
- **Both cases:** the padding and length words are identical.

## Test plan
- **"abc".** One word `0x61626300`, `iBytes`=3, `iLast`.
  - Expect 16 words: `0x61626380`, then 13× `0`, then `0x00000000`, then `0x00000018`.
  - `oBlockEnd` and `oMsgEnd` on word 15; `oBlockCount`=1.
- **55 bytes.** 14 words, the last with `iBytes`=3.
  - Expect word 13 = data | `0x80` in the low byte, word 14 = 0, word 15 = `0x000001B8`.
  - 1 block.
- **56 bytes.** 14 full words, the last with `iBytes`=0.
  - Expect word 14 = `0x80000000` and word 15 = 0, with `oBlockEnd` but no `oMsgEnd`.
  - Then block 2: 14× 0, `0x00000000`, `0x000001C0` with `oMsgEnd`; `oBlockCount`=2.
- **64 bytes, then back-to-back 4 bytes.**
  - First message: block 2 = `0x80000000`, 14× 0, `0x00000200`.
  - Second message: its first word is accepted only after `oMsgEnd` transfers; `oBlockCount` restarts at 1.
- **Backpressure.** "abc", with `iReady` low for 3 cycles at w=5 and at w=15.
  - `oData` and `oValid` held stable; exactly 16 words delivered, none duplicated.
- **Reset and byte swap.**
  - Assert `iRst` at w=7 of the 56-byte case: all outputs at reset values next cycle, and a fresh "abc" then matches the first scenario.
  - With `SHA_PAD_BYTESWAP_EN` defined, input `0x00636261` with `iBytes`=3 yields first word `0x61626380`.
